mul4_rr_sched: RTL and testbench
================================

// Module: mul4_rr_sched
// PURPOSE
//   Round-robin scheduler that shares one pipelined 4-operand multiplier (a*b*c*d, 40-bit)
//   among N_REQ bicubic weight/tap requesters. Arbitrates valid/ready requests, registers
//   the winning operands into the multiplier, tracks each issued tag through the fixed
//   multiplier latency and routes the result back to the issuing requester.
//   Sits between the bicubic coefficient generators and the shared multiplier instance.
// PARAMETERS
//   N_REQ    4   number of requesters (2..8)
//   DW       10  operand width
//   RW       40  multiplier result width
//   MUL_LAT  4   multiplier latency: operands stable at edge k -> mul_result valid after edge k+MUL_LAT
//   IDW      2   requester id width, >= clog2(N_REQ)
// PORTS
//   clk         in   1         system clock
//   rst_n       in   1         asynchronous active-low reset
//   en          in   1         scheduler enable
//   drain_req   in   1         stop granting, flush in-flight ops, return to IDLE
//   req_valid   in   N_REQ     per-requester request
//   req_ready   out  N_REQ     one-hot grant; handshake = valid & ready
//   req_a/b/c/d in   N_REQ*DW  flattened operands; requester i at [i*DW +: DW]
//   mul_a/b/c/d out  DW        registered operands to the multiplier
//   mul_result  in   RW        multiplier output
//   rsp_valid   out  N_REQ     one-hot result strobe, 1 cycle, no backpressure
//   rsp_id      out  IDW       id of the current result
//   rsp_data    out  RW        registered copy of mul_result
//   busy        out  1         any op in flight or state != IDLE
//   drain_done  out  1         1-cycle pulse on DRAIN -> IDLE
// BEHAVIOUR
//   - Reset: state IDLE; req_ready, rsp_valid, rsp_id, rsp_data, mul_a..d, drain_done = 0;
//     busy = 0; rr pointer = N_REQ-1 (requester 0 wins first); all tags invalid.
//   - FSM: IDLE -(en & !drain_req)-> RUN; RUN -(drain_req | !en)-> DRAIN;
//     DRAIN -(tag pipe and rsp stage empty)-> IDLE with drain_done=1 for that cycle.
//     drain_req wins over en. IDLE with drain_req: stays IDLE, no pulse.
//   - Grant: only in RUN; combinational req_ready = one-hot of first req_valid bit searching
//     from ptr+1 with wrap; at most one grant per cycle; ptr <= granted id on handshake,
//     otherwise ptr holds.
//   - Issue: on handshake at edge k, mul_a..d <= granted operands; tag[0] <= {1,id}.
//     No handshake: mul_a..d hold, tag[0] <= invalid.
//   - Tag pipe: MUL_LAT+1 stages shifting every cycle (the multiplier never stalls).
//   - Response: at edge k+MUL_LAT+1, if tag[MUL_LAT] is valid: rsp_valid <= 1<<id,
//     rsp_id <= id, rsp_data <= mul_result; else rsp_valid <= 0 and rsp_id/rsp_data hold.
//     Handshake-to-rsp_valid latency = MUL_LAT+1 = 5 cycles. Throughput 1 op/cycle.
//   - Order: responses leave in issue order; back-to-back grants give back-to-back rsp_valid.
//   - en drop or drain_req mid-stream: in-flight ops still complete and respond; no op is lost.
//   - Reset mid-operation: all in-flight tags discarded, no rsp_valid after reset release.
//   - req_valid dropped without handshake: no effect. Operands are sampled only on handshake.
// CONFIGURATION
//   MUL4_SCHED_PRIO_EN defined: requester 0 has strict priority; when req_valid[0]=1 it is
//     always granted and ptr is not updated; requesters 1..N_REQ-1 round-robin among themselves.
//   Not defined: pure round-robin across all N_REQ requesters as above.
// TESTING
//   1 en=1, req0 a=100 b=200 c=300 d=400 -> req_ready=0001 same cycle; 5 cycles later
//     rsp_valid=0001, rsp_id=0, rsp_data = ((20000>>1)*(120000>>2))<<3 = 2_400_000_000.
//   2 All 4 req_valid held high for 8 cycles -> grants 0,1,2,3,0,1,2,3; 8 consecutive
//     rsp_valid pulses in the same id order, each rsp_data matching the model.
//   3 3 ops in flight, pulse drain_req -> req_ready=0 from the next cycle; 3 responses
//     emerge; drain_done pulses the cycle after the last rsp_valid; busy=0 afterwards.
//   4 4 ops in flight, rst_n=0 for 2 cycles -> all outputs at reset values; no rsp_valid
//     for 10 cycles after release; next grant goes to requester 0.
//   5 req0 and req2 continuously valid: without MUL4_SCHED_PRIO_EN grants alternate
//     0,2,0,2; with it, req0 is granted every cycle and req2 never.
//   6 All operands = 1023 -> rsp_data = ((1046529>>1)*(1046529>>2))<<3, no width truncation.

Source files
------------

// File: rtl/mul4_rr_sched.sv
// -----------------------------------------------------------------------------
// mul4_rr_sched
//   Round-robin scheduler sharing one pipelined 4-operand multiplier among
//   N_REQ requesters. It grants one valid request per cycle and registers the
//   winner's operands into the multiplier. Each issued requester id rides a tag
//   pipe matched to the multiplier latency. When the tag reaches the end of the
//   pipe, the multiplier result is routed back to that requester.
//
//   Optional feature macro: MUL4_SCHED_PRIO_EN
//     defined   : requester 0 has strict priority and does not move the pointer;
//                 requesters 1..N_REQ-1 round-robin among themselves.
//     undefined : pure round-robin across all requesters.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   en                scheduler enable
//   drain_req         stop granting, let in-flight ops finish, return to IDLE
//   req_valid         per-requester request
//   req_ready         one-hot grant (combinational, RUN state only)
//   req_a..req_d      flattened operands, requester i at [i*DW +: DW]
//   mul_a..mul_d      registered operands to the shared multiplier
//   mul_result        multiplier output, valid MUL_LAT edges after operands
//   rsp_valid         one-hot 1-cycle result strobe
//   rsp_id, rsp_data  id and registered result of the current response
//   busy              op in flight or scheduler not IDLE
//   drain_done        1-cycle pulse on DRAIN -> IDLE
// -----------------------------------------------------------------------------
module mul4_rr_sched #(
    parameter int N_REQ   = 4,
    parameter int DW      = 10,
    parameter int RW      = 40,
    parameter int MUL_LAT = 4,
    parameter int IDW     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  drain_req,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*DW-1:0]   req_a,
    input  logic [N_REQ*DW-1:0]   req_b,
    input  logic [N_REQ*DW-1:0]   req_c,
    input  logic [N_REQ*DW-1:0]   req_d,
    output logic [DW-1:0]         mul_a,
    output logic [DW-1:0]         mul_b,
    output logic [DW-1:0]         mul_c,
    output logic [DW-1:0]         mul_d,
    input  logic [RW-1:0]         mul_result,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [RW-1:0]         rsp_data,
    output logic                  busy,
    output logic                  drain_done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       r_state;
    logic [IDW-1:0]   r_ptr;
    logic [MUL_LAT:0] r_tag_vld;
    logic [IDW-1:0]   r_tag_id [MUL_LAT+1];
    logic [DW-1:0]    r_mul_a, r_mul_b, r_mul_c, r_mul_d;
    logic [N_REQ-1:0] r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic [RW-1:0]    r_rsp_data;
    logic             r_drain_done;

    logic [N_REQ-1:0] w_cand;
    logic [N_REQ-1:0] w_grant;
    logic [IDW-1:0]   w_gnt_id;
    logic             w_found;
    logic             w_ptr_upd;
    logic [DW-1:0]    w_op_a, w_op_b, w_op_c, w_op_d;
    logic [N_REQ-1:0] w_rsp_oh;

    // Arbitration: walk offsets 1..N_REQ from the pointer so the last winner
    // is considered last; the first valid candidate wins.
    always_comb begin
        int unsigned pos;
        pos      = 0;
        w_grant  = '0;
        w_gnt_id = '0;
        w_found  = 1'b0;
        w_cand   = (r_state == ST_RUN) ? req_valid : '0;
`ifdef MUL4_SCHED_PRIO_EN
        if (w_cand[0]) begin
            w_grant[0] = 1'b1;
            w_found    = 1'b1;
        end
`endif
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            pos = 32'(r_ptr) + off;
            if (pos >= N_REQ) pos = pos - N_REQ;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!w_found && pos == i && w_cand[i]) begin
                    w_found    = 1'b1;
                    w_grant[i] = 1'b1;
                    w_gnt_id   = IDW'(i);
                end
            end
        end
    end

`ifdef MUL4_SCHED_PRIO_EN
    // Priority grants to requester 0 leave the rotation of the others untouched.
    assign w_ptr_upd = w_found & ~w_grant[0];
`else
    assign w_ptr_upd = w_found;
`endif

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        w_op_c = '0;
        w_op_d = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_op_a = req_a[i*DW +: DW];
                w_op_b = req_b[i*DW +: DW];
                w_op_c = req_c[i*DW +: DW];
                w_op_d = req_d[i*DW +: DW];
            end
        end
    end

    always_comb begin
        w_rsp_oh = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (r_tag_id[MUL_LAT] == IDW'(i)) w_rsp_oh[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ptr        <= IDW'(N_REQ - 1);
            r_tag_vld    <= '0;
            for (int unsigned i = 0; i <= MUL_LAT; i++) r_tag_id[i] <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_mul_c      <= '0;
            r_mul_d      <= '0;
            r_rsp_valid  <= '0;
            r_rsp_id     <= '0;
            r_rsp_data   <= '0;
            r_drain_done <= 1'b0;
        end else begin
            r_drain_done <= 1'b0;
            case (r_state)
                ST_IDLE:  if (en && !drain_req) r_state <= ST_RUN;
                ST_RUN:   if (drain_req || !en) r_state <= ST_DRAIN;
                ST_DRAIN: begin
                    // Tag at the last stage has been handed to the response
                    // stage once it leaves the pipe, so an empty pipe is enough.
                    if (!(|r_tag_vld)) begin
                        r_state      <= ST_IDLE;
                        r_drain_done <= 1'b1;
                    end
                end
                default:  r_state <= ST_IDLE;
            endcase

            if (w_found) begin
                r_mul_a <= w_op_a;
                r_mul_b <= w_op_b;
                r_mul_c <= w_op_c;
                r_mul_d <= w_op_d;
            end
            if (w_ptr_upd) r_ptr <= w_gnt_id;

            // The multiplier never stalls, so the tag pipe shifts every cycle.
            r_tag_vld   <= {r_tag_vld[MUL_LAT-1:0], w_found};
            r_tag_id[0] <= w_gnt_id;
            for (int unsigned i = 1; i <= MUL_LAT; i++) r_tag_id[i] <= r_tag_id[i-1];

            if (r_tag_vld[MUL_LAT]) begin
                r_rsp_valid <= w_rsp_oh;
                r_rsp_id    <= r_tag_id[MUL_LAT];
                r_rsp_data  <= mul_result;
            end else begin
                r_rsp_valid <= '0;
            end
        end
    end

    assign req_ready  = w_grant;
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign mul_c      = r_mul_c;
    assign mul_d      = r_mul_d;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;
    assign busy       = (r_state != ST_IDLE) || (|r_tag_vld);
    assign drain_done = r_drain_done;

endmodule

// File: tb/tb_mul4_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_mul4_rr_sched
//   Self-checking bench for mul4_rr_sched. Contains a stub pipelined multiplier
//   and a scoreboard model that tracks expected grants and due cycles of
//   responses. Honours MUL4_SCHED_PRIO_EN for expected arbitration order.
// -----------------------------------------------------------------------------
module tb_mul4_rr_sched;
    localparam int N   = 4;
    localparam int DW  = 10;
    localparam int RW  = 40;
    localparam int LAT = 4;
    localparam int IDW = 2;
`ifdef MUL4_SCHED_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic            drain_req = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_a = '0, req_b = '0, req_c = '0, req_d = '0;
    logic [DW-1:0]   mul_a, mul_b, mul_c, mul_d;
    logic [RW-1:0]   mul_result;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic [RW-1:0]   rsp_data;
    logic            busy, drain_done;

    always #5 clk = ~clk;

    mul4_rr_sched #(.N_REQ(N), .DW(DW), .RW(RW), .MUL_LAT(LAT), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .drain_req(drain_req),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_d(mul_d),
        .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy), .drain_done(drain_done)
    );

    function automatic logic [RW-1:0] f(input logic [DW-1:0] a, b, c, d);
        logic [63:0] ab, cd, p;
        ab = 64'(a) * 64'(b);
        cd = 64'(c) * 64'(d);
        p  = ((ab >> 1) * (cd >> 2)) << 3;
        return p[RW-1:0];
    endfunction

    // Stub multiplier: LAT register stages
    logic [RW-1:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= f(mul_a, mul_b, mul_c, mul_d);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_result = mpipe[LAT-1];

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_RUN, M_DRAIN} mstate_t;
    typedef struct { int due; int id; logic [RW-1:0] data; } pend_t;
    pend_t          q[$];
    mstate_t        m_state;
    int             m_last, m_gnt, cyc;
    logic [4*DW-1:0] m_ops;
    logic [IDW-1:0] m_rsp_id;
    logic [RW-1:0]  m_rsp_data;
    logic           m_dd;
    int             n_checks = 0, n_errors = 0;

    logic [N-1:0]   s_ready, s_rv;
    logic [IDW-1:0] s_id;
    logic [RW-1:0]  s_data;
    logic           s_busy, s_dd;

    function automatic logic [N-1:0] oh(input int id);
        logic [N-1:0] r;
        r = '0;
        if (id >= 0) r[id] = 1'b1;
        return r;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_state    = M_IDLE;
        m_last     = N - 1;
        m_ops      = '0;
        m_rsp_id   = '0;
        m_rsp_data = '0;
        m_dd       = 1'b0;
    endfunction

    function automatic int exp_grant(input logic [N-1:0] v);
        int id;
        if (m_state != M_RUN) return -1;
        if (PRIO) begin
            if (v[0]) return 0;
            for (int i = 1; i < N; i++) begin
                id = 1 + ((m_last - 1 + i) % (N - 1));
                if (v[id]) return id;
            end
        end else begin
            for (int i = 1; i <= N; i++) begin
                id = (m_last + i) % N;
                if (v[id]) return id;
            end
        end
        return -1;
    endfunction

    function automatic void model_update();
        logic [DW-1:0] a, b, c, d;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_dd = 1'b0;
        if (m_gnt >= 0) begin
            a = req_a[m_gnt*DW +: DW];
            b = req_b[m_gnt*DW +: DW];
            c = req_c[m_gnt*DW +: DW];
            d = req_d[m_gnt*DW +: DW];
            q.push_back('{due: cyc + 6, id: m_gnt, data: f(a, b, c, d)});
            m_ops = {a, b, c, d};
            if (!PRIO || m_gnt != 0) m_last = m_gnt;
        end
        case (m_state)
            M_IDLE:  if (en && !drain_req) m_state = M_RUN;
            M_RUN:   if (drain_req || !en) m_state = M_DRAIN;
            M_DRAIN: if (q.size() == 0) begin m_state = M_IDLE; m_dd = 1'b1; end
            default: m_state = M_IDLE;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample/check at negedge, advance model at posedge, return at posedge+1.
    task automatic tick();
        logic [N-1:0] exp_rv;
        @(negedge clk);
        s_ready = req_ready; s_rv = rsp_valid; s_id = rsp_id; s_data = rsp_data;
        s_busy = busy; s_dd = drain_done;
        m_gnt  = exp_grant(req_valid);
        exp_rv = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_rv     = oh(q[0].id);
            m_rsp_id   = IDW'(q[0].id);
            m_rsp_data = q[0].data;
            void'(q.pop_front());
        end
        chk("req_ready", 64'(s_ready), 64'(oh(m_gnt)));
        chk("rsp_valid", 64'(s_rv), 64'(exp_rv));
        chk("rsp_id", 64'(s_id), 64'(m_rsp_id));
        chk("rsp_data", 64'(s_data), 64'(m_rsp_data));
        chk("mul_ops", 64'({mul_a, mul_b, mul_c, mul_d}), 64'(m_ops));
        chk("busy", 64'(s_busy), 64'(m_state != M_IDLE || q.size() > 0));
        chk("drain_done", 64'(s_dd), 64'(m_dd));
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic set_in(input logic e, input logic dr, input logic [N-1:0] v);
        en = e; drain_req = dr; req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW] = DW'($urandom);
            req_b[i*DW +: DW] = DW'($urandom);
            req_c[i*DW +: DW] = DW'($urandom);
            req_d[i*DW +: DW] = DW'($urandom);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin tick(); n++; end while (s_rv == '0 && n < 12);
    endtask

    typedef struct { logic [N-1:0] v; logic [N-1:0] rr; logic [N-1:0] pr; } vec_t;
    vec_t tbl [12];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n, rc, rdy, last_t, first_t, dd_t;
        logic [N-1:0] e;

        tbl[0]  = '{4'b1111, 4'b0001, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0010, 4'b0001};
        tbl[2]  = '{4'b1110, 4'b0100, 4'b0010};
        tbl[3]  = '{4'b1110, 4'b1000, 4'b0100};
        tbl[4]  = '{4'b1110, 4'b0010, 4'b1000};
        tbl[5]  = '{4'b0101, 4'b0100, 4'b0001};
        tbl[6]  = '{4'b0101, 4'b0001, 4'b0001};
        tbl[7]  = '{4'b0101, 4'b0100, 4'b0001};
        tbl[8]  = '{4'b0000, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b1000, 4'b1000, 4'b1000};
        tbl[10] = '{4'b0100, 4'b0100, 4'b0100};
        tbl[11] = '{4'b0001, 4'b0001, 4'b0001};

        cyc = 0;
        m_gnt = -1;
        model_reset();
        set_in(1'b0, 1'b0, '0);
        repeat (2) tick();
        chk("reset_busy", 64'(s_busy), 64'd0);
        chk("reset_ready", 64'(s_ready), 64'd0);
        rst_n = 1'b1;

        // Arbitration order table from a fresh pointer
        set_in(1'b1, 1'b0, '0); tick();
        for (int i = 0; i < 12; i++) begin
            set_in(1'b1, 1'b0, tbl[i].v);
            tick();
            chk("tbl_ready", 64'(s_ready), 64'(PRIO ? tbl[i].pr : tbl[i].rr));
        end

        // Single op: latency and data
        do_reset(2);
        set_in(1'b1, 1'b0, '0); tick();
        set_in(1'b1, 1'b0, 4'b0001);
        req_a[0 +: DW] = 10'd100; req_b[0 +: DW] = 10'd200;
        req_c[0 +: DW] = 10'd300; req_d[0 +: DW] = 10'd400;
        tick();
        chk("t1_ready", 64'(s_ready), 64'd1);
        set_in(1'b1, 1'b0, '0);
        wait_rsp(n);
        chk("t1_latency", 64'(n - 1), 64'(LAT + 1));
        chk("t1_rsp_valid", 64'(s_rv), 64'd1);
        chk("t1_rsp_id", 64'(s_id), 64'd0);
        chk("t1_rsp_data", 64'(s_data), 64'd2400000000);

        // All requesters valid: order of grants and back-to-back responses
        do_reset(2);
        set_in(1'b1, 1'b0, '0); tick();
        rc = 0; first_t = -1; last_t = -1;
        for (int t = 0; t < 16; t++) begin
            set_in(1'b1, 1'b0, (t < 8) ? 4'b1111 : 4'b0000);
            tick();
            if (t < 8) chk("t2_grant", 64'(s_ready), 64'(oh(PRIO ? 0 : t % 4)));
            if (s_rv != '0) begin
                chk("t2_rsp_order", 64'(s_rv), 64'(oh(PRIO ? 0 : rc % 4)));
                if (first_t < 0) first_t = t;
                last_t = t;
                rc++;
            end
        end
        chk("t2_rsp_count", 64'(rc), 64'd8);
        chk("t2_back_to_back", 64'(last_t - first_t), 64'd7);

        // req0 and req2 continuously valid
        do_reset(2);
        set_in(1'b1, 1'b0, '0); tick();
        for (int t = 0; t < 6; t++) begin
            set_in(1'b1, 1'b0, 4'b0101);
            tick();
            chk("t5_grant", 64'(s_ready), 64'((PRIO || t % 2 == 0) ? 4'b0001 : 4'b0100));
        end
        set_in(1'b1, 1'b0, '0);
        repeat (8) tick();

        // Maximum operands, no truncation
        set_in(1'b1, 1'b0, 4'b0010);
        req_a = '1; req_b = '1; req_c = '1; req_d = '1;
        tick();
        chk("t6_ready", 64'(s_ready), 64'(4'b0010));
        set_in(1'b1, 1'b0, '0);
        wait_rsp(n);
        chk("t6_rsp_id", 64'(s_id), 64'd1);
        chk("t6_rsp_data", 64'(s_data), 64'd1095220854784);

        // Drain with three ops in flight
        set_in(1'b1, 1'b0, 4'b1111); tick();
        set_in(1'b1, 1'b0, 4'b1111); tick();
        set_in(1'b1, 1'b1, 4'b1111); tick();
        rc = 0; rdy = 0; last_t = -10; dd_t = -1;
        for (int t = 0; t < 20; t++) begin
            set_in(1'b1, 1'b0, 4'b1111);
            tick();
            if (s_ready != '0) rdy++;
            if (s_rv != '0) begin rc++; last_t = t; end
            if (s_dd) begin
                dd_t = t;
                chk("t3_busy_after", 64'(s_busy), 64'd0);
                break;
            end
        end
        chk("t3_rsp_count", 64'(rc), 64'd3);
        chk("t3_no_grant", 64'(rdy), 64'd0);
        chk("t3_done_timing", 64'(dd_t), 64'(last_t + 1));
        set_in(1'b0, 1'b0, '0); tick();

        // Reset with four ops in flight
        do_reset(1);
        set_in(1'b1, 1'b0, '0); tick();
        repeat (4) begin set_in(1'b1, 1'b0, 4'b1111); tick(); end
        set_in(1'b0, 1'b0, '0);
        rst_n = 1'b0;
        model_reset();
        tick();
        chk("t4_rst_busy", 64'(s_busy), 64'd0);
        chk("t4_rst_mul", 64'({mul_a, mul_b, mul_c, mul_d}), 64'd0);
        tick();
        rst_n = 1'b1;
        rc = 0;
        repeat (10) begin tick(); if (s_rv != '0) rc++; end
        chk("t4_no_rsp", 64'(rc), 64'd0);
        set_in(1'b1, 1'b0, '0); tick();
        set_in(1'b1, 1'b0, 4'b1111); tick();
        chk("t4_first_grant", 64'(s_ready), 64'd1);

        // Randomized traffic against the model
        for (int t = 0; t < 3000; t++) begin
            e = N'($urandom);
            set_in($urandom_range(0, 99) < 92, $urandom_range(0, 99) < 3, e);
            if ($urandom_range(0, 499) == 0) do_reset(1 + $urandom_range(0, 1));
            else tick();
        end
        set_in(1'b0, 1'b0, '0);
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
